// File: rtl/alu_result_buffer.sv
// Result buffer behind the ALU: FIFO of {result, overflow} entries with a sticky overflow flag
// and a saturating overflow counter. Define ALU_BUF_BYPASS_EN for empty-FIFO combinational bypass.
module alu_result_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WIDTH-1:0]           RES,
  input  logic                       OVF,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  output logic [WIDTH-1:0]           DOUT,
  output logic                       DOUT_OVF,
  output logic                       DOUT_VALID,
  input  logic                       DOUT_READY,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       STICKY_OVF,
  input  logic                       CLR_OVF,
  output logic [CNT_W-1:0]           OVF_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Handshake: an entry moves on a CLK edge only where valid and ready are both high;
  // valid never waits on ready, and an input offered while not ready is lost.

  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            sticky;
  logic [CNT_W-1:0] ovf_cnt;

  logic not_empty;
  logic accept;
  logic bypass;
  logic store;
  logic pop;

  assign not_empty = (count != '0);
  assign IN_READY  = (count != FULL);
  assign accept    = IN_VALID & IN_READY;

`ifdef ALU_BUF_BYPASS_EN
  assign bypass = ~not_empty & IN_VALID & DOUT_READY;
`else
  assign bypass = 1'b0;
`endif

  assign store = accept & ~bypass;
  assign pop   = not_empty & DOUT_READY;

  always_comb begin
    DOUT       = '0;
    DOUT_OVF   = 1'b0;
    DOUT_VALID = not_empty | bypass;
    if (not_empty) begin
      DOUT     = mem[rd_ptr][WIDTH-1:0];
      DOUT_OVF = mem[rd_ptr][WIDTH];
    end else if (bypass) begin
      DOUT     = RES;
      DOUT_OVF = OVF;
    end
  end

  always_ff @(posedge CLK) begin
    if (store) mem[wr_ptr] <= {OVF, RES};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      sticky  <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new overflow in the same cycle as a clear must not be lost.
      if (accept & OVF)    sticky <= 1'b1;
      else if (CLR_OVF)    sticky <= 1'b0;
      if (accept & OVF & (ovf_cnt != {CNT_W{1'b1}})) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  assign COUNT      = count;
  assign STICKY_OVF = sticky;
  assign OVF_CNT    = ovf_cnt;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_alu_result_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic [WIDTH-1:0] res = '0;
  logic             ovf = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_ovf;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
  logic [2:0]       count;
  logic             sticky_ovf;
  logic             clr_ovf = 1'b0;
  logic [CNT_W-1:0] ovf_cnt;

  // second instance with a 2-bit counter for saturation
  logic [WIDTH-1:0] res2 = '0;
  logic             ovf2 = 1'b0;
  logic             in_valid2 = 1'b0;
  logic             in_ready2;
  logic [WIDTH-1:0] dout2;
  logic             dout_ovf2;
  logic             dout_valid2;
  logic [2:0]       count2;
  logic             sticky_ovf2;
  logic [1:0]       ovf_cnt2;

  alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RST(rst), .RES(res), .OVF(ovf), .IN_VALID(in_valid), .IN_READY(in_ready),
    .DOUT(dout), .DOUT_OVF(dout_ovf), .DOUT_VALID(dout_valid), .DOUT_READY(dout_ready),
    .COUNT(count), .STICKY_OVF(sticky_ovf), .CLR_OVF(clr_ovf), .OVF_CNT(ovf_cnt)
  );

  alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .CLK(clk), .RST(rst), .RES(res2), .OVF(ovf2), .IN_VALID(in_valid2), .IN_READY(in_ready2),
    .DOUT(dout2), .DOUT_OVF(dout_ovf2), .DOUT_VALID(dout_valid2), .DOUT_READY(1'b1),
    .COUNT(count2), .STICKY_OVF(sticky_ovf2), .CLR_OVF(1'b0), .OVF_CNT(ovf_cnt2)
  );

  int total = 0;
  int bad   = 0;

  // reference model: queue of {ovf, res}
  logic [WIDTH:0] exp_q[$];
  bit             m_sticky = 1'b0;
  int             m_cnt    = 0;

  function automatic bit model_bypass();
`ifdef ALU_BUF_BYPASS_EN
    return (exp_q.size() == 0) && in_valid && dout_ready;
`else
    return 1'b0;
`endif
  endfunction

  // expected outputs for the current inputs and model state
  task automatic get_exp(output logic [WIDTH-1:0] e_dout, output logic e_ovf,
                         output logic e_valid, output logic e_ready, output logic [2:0] e_count,
                         output logic e_sticky, output logic [CNT_W-1:0] e_cnt);
    logic [WIDTH:0] head;
    e_dout  = '0;
    e_ovf   = 1'b0;
    e_valid = 1'b0;
    if (exp_q.size() > 0) begin
      head    = exp_q[0];
      e_dout  = head[WIDTH-1:0];
      e_ovf   = head[WIDTH];
      e_valid = 1'b1;
    end else if (model_bypass()) begin
      e_dout  = res;
      e_ovf   = ovf;
      e_valid = 1'b1;
    end
    e_ready  = (exp_q.size() < DEPTH);
    e_count  = 3'(exp_q.size());
    e_sticky = m_sticky;
    e_cnt    = (m_cnt > CMAX) ? CNT_W'(CMAX) : CNT_W'(m_cnt);
  endtask

  task automatic model_step();
    bit acc;
    bit byp;
    if (rst) begin
      exp_q.delete();
      m_sticky = 1'b0;
      m_cnt    = 0;
      return;
    end
    acc = in_valid && (exp_q.size() < DEPTH);
    byp = model_bypass();
    if (exp_q.size() > 0 && dout_ready) void'(exp_q.pop_front());
    if (acc && !byp) exp_q.push_back({ovf, res});
    if (acc && ovf) begin
      m_sticky = 1'b1;
      m_cnt++;
    end else if (clr_ovf) begin
      m_sticky = 1'b0;
    end
  endtask

  // advance one clock; inputs are driven and outputs sampled between negedges
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; dout_ready = 1'b0; clr_ovf = 1'b0; ovf = 1'b0; res = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    #1;
    total++; if (count !== 3'd0)       begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (dout_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
    total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    total++; if (sticky_ovf !== 1'b0)  begin bad++; $display("FAIL reset_sticky got=%b exp=0", sticky_ovf); end
    total++; if (ovf_cnt !== '0)       begin bad++; $display("FAIL reset_ovf_cnt got=%0d exp=0", ovf_cnt); end
    total++; if (dout !== '0)          begin bad++; $display("FAIL reset_dout got=%0d exp=0", dout); end
  endtask

  task automatic test_single_push();
    in_valid = 1'b1; res = 8'd6; ovf = 1'b0; dout_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (dout !== 8'd6)        begin bad++; $display("FAIL single_dout got=%0d exp=6", dout); end
    total++; if (dout_valid !== 1'b1)  begin bad++; $display("FAIL single_valid got=%b exp=1", dout_valid); end
    total++; if (count !== 3'd1)       begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
    total++; if (sticky_ovf !== 1'b0)  begin bad++; $display("FAIL single_sticky got=%b exp=0", sticky_ovf); end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    #1;
    total++; if (count !== 3'd0)       begin bad++; $display("FAIL single_drain_count got=%0d exp=0", count); end
  endtask

  task automatic test_fill_drain();
    logic [WIDTH-1:0] vals [4];
    logic             ovfs [4];
    vals = '{8'd6, 8'd11, 8'd3, 8'd8};
    ovfs = '{1'b0, 1'b1, 1'b0, 1'b1};
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; res = vals[i]; ovf = ovfs[i];
      tick();
    end
    total++; if (count !== 3'd4)     begin bad++; $display("FAIL fill_count got=%0d exp=4", count); end
    total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL fill_ready got=%b exp=0", in_ready); end
    res = 8'd0; ovf = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (count !== 3'd4)     begin bad++; $display("FAIL drop_count got=%0d exp=4", count); end
    dout_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dout !== vals[i] || dout_ovf !== ovfs[i] || dout_valid !== 1'b1) begin
        bad++;
        $display("FAIL drain_order[%0d] got=%0d/%b/%b exp=%0d/%b/1", i, dout, dout_ovf, dout_valid, vals[i], ovfs[i]);
      end
      tick();
    end
    dout_ready = 1'b0;
    #1;
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", dout_valid); end
    total++; if (sticky_ovf !== 1'b1) begin bad++; $display("FAIL drain_sticky got=%b exp=1", sticky_ovf); end
    total++; if (ovf_cnt !== 8'd2)    begin bad++; $display("FAIL drain_ovf_cnt got=%0d exp=2", ovf_cnt); end
  endtask

  task automatic test_sticky_clr();
    in_valid = 1'b1; res = 8'($urandom); ovf = 1'b1; clr_ovf = 1'b1; dout_ready = 1'b0;
    tick();
    in_valid = 1'b0; ovf = 1'b0;
    #1;
    total++; if (sticky_ovf !== 1'b1) begin bad++; $display("FAIL clr_vs_set got=%b exp=1", sticky_ovf); end
    total++; if (ovf_cnt !== 8'd3)    begin bad++; $display("FAIL clr_vs_set_cnt got=%0d exp=3", ovf_cnt); end
    tick();
    clr_ovf = 1'b0;
    #1;
    total++; if (sticky_ovf !== 1'b0) begin bad++; $display("FAIL clr_alone got=%b exp=0", sticky_ovf); end
    total++; if (ovf_cnt !== 8'd3)    begin bad++; $display("FAIL clr_keeps_cnt got=%0d exp=3", ovf_cnt); end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] e_dout; logic e_ovf, e_valid, e_ready, e_sticky;
    logic [2:0] e_count; logic [CNT_W-1:0] e_cnt;
    dout_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; res = 8'($urandom); ovf = 1'($urandom_range(0, 1));
      tick();
    end
    res = 8'($urandom); ovf = 1'($urandom_range(0, 1)); dout_ready = 1'b1;
    #1;
    get_exp(e_dout, e_ovf, e_valid, e_ready, e_count, e_sticky, e_cnt);
    total++; if (dout !== e_dout)   begin bad++; $display("FAIL full_head got=%0d exp=%0d", dout, e_dout); end
    tick();
    total++; if (count !== 3'd3)    begin bad++; $display("FAIL full_pop_count got=%0d exp=3", count); end
    for (int i = 0; i < 10 * DEPTH; i++) begin
      res = 8'($urandom); ovf = 1'($urandom_range(0, 1));
      #1;
      get_exp(e_dout, e_ovf, e_valid, e_ready, e_count, e_sticky, e_cnt);
      total++;
      if (dout !== e_dout || dout_ovf !== e_ovf || count !== 3'd3) begin
        bad++;
        $display("FAIL wrap[%0d] got=%0d/%b cnt=%0d exp=%0d/%b cnt=3", i, dout, dout_ovf, count, e_dout, e_ovf);
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) tick();
    dout_ready = 1'b0;
    #1;
    total++; if (count !== 3'd0)    begin bad++; $display("FAIL wrap_drain got=%0d exp=0", count); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      in_valid2 = 1'b1; res2 = 8'($urandom); ovf2 = 1'b1;
      tick();
      if (i == 1) begin
        total++; if (ovf_cnt2 !== 2'd2) begin bad++; $display("FAIL sat_mid got=%0d exp=2", ovf_cnt2); end
      end
    end
    in_valid2 = 1'b0; ovf2 = 1'b0;
    #1;
    total++; if (ovf_cnt2 !== 2'd3)    begin bad++; $display("FAIL sat_hold got=%0d exp=3", ovf_cnt2); end
    total++; if (sticky_ovf2 !== 1'b1) begin bad++; $display("FAIL sat_sticky got=%b exp=1", sticky_ovf2); end
  endtask

  task automatic test_mid_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; res = 8'($urandom); ovf = 1'b1;
      tick();
    end
    total++; if (count !== 3'd3)       begin bad++; $display("FAIL pre_reset_count got=%0d exp=3", count); end
    rst = 1'b1; in_valid = 1'b1; dout_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; dout_ready = 1'b0;
    #1;
    total++; if (count !== 3'd0)       begin bad++; $display("FAIL mid_reset_count got=%0d exp=0", count); end
    total++; if (dout_valid !== 1'b0)  begin bad++; $display("FAIL mid_reset_valid got=%b exp=0", dout_valid); end
    total++; if (ovf_cnt !== '0)       begin bad++; $display("FAIL mid_reset_cnt got=%0d exp=0", ovf_cnt); end
  endtask

`ifdef ALU_BUF_BYPASS_EN
  task automatic test_bypass();
    in_valid = 1'b1; res = 8'd5; ovf = 1'b0; dout_ready = 1'b1;
    #1;
    total++; if (dout !== 8'd5 || dout_valid !== 1'b1) begin
      bad++; $display("FAIL bypass_out got=%0d/%b exp=5/1", dout, dout_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bypass_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0; dout_ready = 1'b0;
    #1;
    total++; if (count !== 3'd0)    begin bad++; $display("FAIL bypass_count got=%0d exp=0", count); end
  endtask
`endif

  task automatic test_random();
    logic [WIDTH-1:0] e_dout; logic e_ovf, e_valid, e_ready, e_sticky;
    logic [2:0] e_count; logic [CNT_W-1:0] e_cnt;
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      in_valid   = ($urandom_range(0, 99) < 60);
      dout_ready = ($urandom_range(0, 99) < 45);
      clr_ovf    = ($urandom_range(0, 99) < 10);
      res        = 8'($urandom);
      ovf        = ($urandom_range(0, 99) < 30);
      #1;
      get_exp(e_dout, e_ovf, e_valid, e_ready, e_count, e_sticky, e_cnt);
      total++;
      if (dout !== e_dout || dout_ovf !== e_ovf || dout_valid !== e_valid || in_ready !== e_ready ||
          count !== e_count || sticky_ovf !== e_sticky || ovf_cnt !== e_cnt) begin
        bad++;
        $display("FAIL random[%0d] got d=%0d o=%b v=%b r=%b c=%0d s=%b n=%0d exp d=%0d o=%b v=%b r=%b c=%0d s=%b n=%0d",
                 i, dout, dout_ovf, dout_valid, in_ready, count, sticky_ovf, ovf_cnt,
                 e_dout, e_ovf, e_valid, e_ready, e_count, e_sticky, e_cnt);
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_push();
    test_fill_drain();
    test_sticky_clr();
    test_back_to_back();
    test_saturation();
    test_mid_reset();
`ifdef ALU_BUF_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
